// File: rtl/argmax_tree.sv
// Pipelined winner-take-all: log2(P_NUM) registered compare stages select the
// largest candidate (lowest index on ties) and qualify it against a threshold.

module argmax_cmp #(
  parameter int P_WIDTH = 19,
  parameter int P_IDXW  = 3
) (
  input  logic [P_WIDTH-1:0] a_val,
  input  logic [P_IDXW-1:0]  a_idx,
  input  logic [P_WIDTH-1:0] b_val,
  input  logic [P_IDXW-1:0]  b_idx,
  output logic [P_WIDTH-1:0] w_val,
  output logic [P_IDXW-1:0]  w_idx
);
  // a always carries the lower indices, so >= keeps ties on the lowest index
  logic sel_a;
  assign sel_a = (a_val >= b_val);
  assign w_val = sel_a ? a_val : b_val;
  assign w_idx = sel_a ? a_idx : b_idx;
endmodule

module argmax_tree #(
  parameter int P_WIDTH = 19,
  parameter int P_NUM   = 8,
  parameter int P_IDXW  = $clog2(P_NUM)
) (
  input  logic                     w_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [P_NUM*P_WIDTH-1:0] i_data,
  input  logic [P_WIDTH-1:0]       i_thresh,
  output logic                     o_valid,
  output logic [P_WIDTH-1:0]       o_result,
  output logic [P_NUM-1:0]         o_onehot,
  output logic [P_IDXW-1:0]        o_index,
  output logic                     o_zero,
  output logic                     o_hit
);
  localparam int S = $clog2(P_NUM);

  logic [S-1:0] vld_q;
  logic [S:0]   vld_pipe;
  assign vld_pipe = {vld_q, i_valid};
  assign o_valid  = vld_q[S-1];

  always_ff @(posedge w_clk or negedge i_rst_n) begin
    if (!i_rst_n) vld_q <= '0;
    else          vld_q <= vld_pipe[S-1:0];
  end

  genvar s, j, k;
  for (s = 1; s <= S; s++) begin : g_st
    localparam int N = P_NUM >> s;
    logic [2*N-1:0][P_WIDTH-1:0] src_val;
    logic [2*N-1:0][P_IDXW-1:0]  src_idx;
    logic [P_WIDTH-1:0]          src_thr;
    logic                        src_zero;
    logic [N-1:0][P_WIDTH-1:0]   win_val;
    logic [N-1:0][P_IDXW-1:0]    win_idx;

    if (s == 1) begin : g_src
      assign src_val  = i_data;
      assign src_thr  = i_thresh;
      assign src_zero = ~|i_data;
      for (k = 0; k < P_NUM; k++) begin : g_idx
        assign src_idx[k] = P_IDXW'(k);
      end
    end else begin : g_src
      assign src_val  = g_st[s-1].g_reg.val_q;
      assign src_idx  = g_st[s-1].g_reg.idx_q;
      assign src_thr  = g_st[s-1].g_reg.thr_q;
      assign src_zero = g_st[s-1].g_reg.zero_q;
    end

    for (j = 0; j < N; j++) begin : g_cmp
      argmax_cmp #(.P_WIDTH(P_WIDTH), .P_IDXW(P_IDXW)) u_cmp (
        .a_val (src_val[2*j]),
        .a_idx (src_idx[2*j]),
        .b_val (src_val[2*j+1]),
        .b_idx (src_idx[2*j+1]),
        .w_val (win_val[j]),
        .w_idx (win_idx[j])
      );
    end

    if (s < S) begin : g_reg
      logic [N-1:0][P_WIDTH-1:0] val_q;
      logic [N-1:0][P_IDXW-1:0]  idx_q;
      logic [P_WIDTH-1:0]        thr_q;
      logic                      zero_q;
      always_ff @(posedge w_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          val_q  <= '0;
          idx_q  <= '0;
          thr_q  <= '0;
          zero_q <= 1'b1;
        end else if (vld_pipe[s-1]) begin
          val_q  <= win_val;
          idx_q  <= win_idx;
          thr_q  <= src_thr;
          zero_q <= src_zero;
        end
      end
    end else begin : g_out
      // last stage registers the qualified result straight onto the ports
      always_ff @(posedge w_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          o_result <= '0;
          o_onehot <= '0;
          o_index  <= '0;
          o_zero   <= 1'b1;
          o_hit    <= 1'b0;
        end else if (vld_pipe[s-1]) begin
          o_result <= win_val[0];
          o_onehot <= src_zero ? '0 : (P_NUM'(1) << win_idx[0]);
          o_index  <= src_zero ? '0 : win_idx[0];
          o_zero   <= src_zero;
          o_hit    <= !src_zero && (win_val[0] >= src_thr);
        end
      end
    end
  end
endmodule

// File: tb/tb_argmax_tree.sv
// Randomized + directed bench for argmax_tree (P_WIDTH=19, P_NUM=8, S=3)
// against a plain max-search reference model with a latency queue.

module tb_argmax_tree;
  localparam int W = 19;
  localparam int N = 8;
  localparam int IW = 3;
  localparam int S = 3;

  logic            w_clk = 1'b0;
  logic            i_rst_n;
  logic            i_valid;
  logic [N*W-1:0]  i_data;
  logic [W-1:0]    i_thresh;
  logic            o_valid;
  logic [W-1:0]    o_result;
  logic [N-1:0]    o_onehot;
  logic [IW-1:0]   o_index;
  logic            o_zero;
  logic            o_hit;

  argmax_tree #(.P_WIDTH(W), .P_NUM(N)) dut (
    .w_clk    (w_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .i_thresh (i_thresh),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_onehot (o_onehot),
    .o_index  (o_index),
    .o_zero   (o_zero),
    .o_hit    (o_hit)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic          v;
    logic [W-1:0]  res;
    logic [N-1:0]  oh;
    logic [IW-1:0] idx;
    logic          z;
    logic          h;
  } exp_t;

  int   n_chk = 0;
  int   n_pass = 0;
  logic [W-1:0] cur [N];
  logic [W-1:0] cur_thr;
  exp_t q[$];
  exp_t last;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  function automatic exp_t model(input logic v);
    exp_t e;
    int   bi = 0;
    logic [W-1:0] best = cur[0];
    logic z = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (cur[k] != 0) z = 1'b0;
      if (cur[k] > best) begin best = cur[k]; bi = k; end
    end
    e.v   = v;
    e.res = best;
    e.z   = z;
    e.idx = z ? '0 : IW'(bi);
    e.oh  = z ? '0 : N'(1) << bi;
    e.h   = !z && (best >= cur_thr);
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.v = 0; e.res = 0; e.oh = 0; e.idx = 0; e.z = 1; e.h = 0;
    return e;
  endfunction

  task automatic chk_outs();
    chk("result", 32'(o_result), 32'(last.res));
    chk("onehot", 32'(o_onehot), 32'(last.oh));
    chk("index",  32'(o_index),  32'(last.idx));
    chk("zero",   32'(o_zero),   32'(last.z));
    chk("hit",    32'(o_hit),    32'(last.h));
  endtask

  task automatic tick(input logic v);
    exp_t e;
    logic ev;
    @(negedge w_clk);
    i_valid = v;
    for (int k = 0; k < N; k++) i_data[k*W +: W] = cur[k];
    i_thresh = cur_thr;
    @(posedge w_clk);
    #1;
    q.push_back(model(v));
    ev = 1'b0;
    if (q.size() >= S) begin
      e = q.pop_front();
      ev = e.v;
      if (e.v) last = e;
    end
    chk("valid", 32'(o_valid), 32'(ev));
    chk_outs();
  endtask

  task automatic set_all(input logic [W-1:0] val, input logic [W-1:0] thr);
    for (int k = 0; k < N; k++) cur[k] = val;
    cur_thr = thr;
  endtask

  task automatic do_reset();
    @(negedge w_clk);
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    q.delete();
    last = reset_exp();
    chk("rst_valid", 32'(o_valid), 0);
    chk_outs();
    @(posedge w_clk);
    #1;
    chk("rst_valid2", 32'(o_valid), 0);
    chk_outs();
    @(negedge w_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_thresh = '0;
    set_all(0, 0);
    last = reset_exp();
    repeat (2) @(posedge w_clk);
    #1;
    chk("init_valid", 32'(o_valid), 0);
    chk_outs();
    @(negedge w_clk);
    i_rst_n = 1'b1;

    // unique max
    cur[0] = 5; cur[1] = 9; cur[2] = 3; cur[3] = 100;
    cur[4] = 7; cur[5] = 0; cur[6] = 2; cur[7] = 1; cur_thr = 50;
    tick(1);
    repeat (4) tick(0);
    chk("um_res", 32'(o_result), 100);
    chk("um_idx", 32'(o_index), 3);
    chk("um_oh",  32'(o_onehot), 32'h08);
    chk("um_hit", 32'(o_hit), 1);
    chk("um_zero", 32'(o_zero), 0);

    // tie plus threshold miss
    cur[0] = 4; cur[1] = 20; cur[2] = 20; cur[3] = 3;
    cur[4] = 20; cur[5] = 0; cur[6] = 0; cur[7] = 0; cur_thr = 21;
    tick(1);
    repeat (3) tick(0);
    chk("tie_res", 32'(o_result), 20);
    chk("tie_idx", 32'(o_index), 1);
    chk("tie_oh",  32'(o_onehot), 32'h02);
    chk("tie_hit", 32'(o_hit), 0);

    // tie at top of range
    set_all(19'h7FFFF, 19'h7FFFF);
    tick(1);
    repeat (3) tick(0);
    chk("top_idx", 32'(o_index), 0);
    chk("top_hit", 32'(o_hit), 1);

    // all zero
    set_all(0, 0);
    tick(1);
    repeat (3) tick(0);
    chk("z_zero", 32'(o_zero), 1);
    chk("z_oh",   32'(o_onehot), 0);
    chk("z_hit",  32'(o_hit), 0);

    // streaming, then 1,0,1 gap pattern
    for (int s = 0; s < N; s++) begin
      set_all(0, 500);
      cur[s] = W'(1000 + s);
      tick(1);
    end
    set_all(0, 0);
    cur[5] = 77;
    tick(1);
    tick(0);
    cur[2] = 88;
    tick(1);
    repeat (4) tick(0);

    // reset with two samples in flight
    set_all(0, 10);
    cur[6] = 55;
    tick(1);
    cur[1] = 66;
    tick(1);
    do_reset();
    set_all(0, 0);
    repeat (4) tick(0);
    cur[4] = 321; cur[7] = 321; cur_thr = 400;
    tick(1);
    repeat (3) tick(0);
    chk("post_rst_idx", 32'(o_index), 4);
    chk("post_rst_res", 32'(o_result), 321);

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      int mode = $urandom_range(0, 3);
      for (int k = 0; k < N; k++) begin
        case (mode)
          0: cur[k] = W'($urandom);
          1: cur[k] = W'($urandom_range(0, 3));
          2: cur[k] = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
          default: cur[k] = ($urandom_range(0, 1) == 0) ? 19'h7FFFF : W'($urandom_range(0, 2));
        endcase
      end
      cur_thr = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom_range(0, 4));
      tick(logic'($urandom_range(0, 3) != 0));
    end
    set_all(0, 0);
    repeat (4) tick(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
